i2c_byte_gen: RTL and testbench

I2C master byte engine that sits between the start generator and the stop generator in the I2C master datapath. It shifts one byte MSB-first onto the bus (write) or off the bus (read), then handles the 9th ACK bit. It drives open-drain SDA/SCL request lines, senses the real bus lines, and honours slave clock stretching. On completion it leaves SCL low, so the stop generator or another byte can follow directly.

---
 rtl/i2c_pkg.sv | 10 +
 rtl/i2c_phase_timer.sv | 19 +
 rtl/i2c_byte_gen.sv | 128 ++++++++++++
 tb/tb_i2c_byte_gen.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// i2c_pkg: state encoding, drive levels and timing helper shared by the I2C
// master start, byte and stop generators.
package i2c_pkg;
  typedef enum logic [2:0] {IDLE, WAIT, SDA_SET, CLK_UP, SAMPLE, CLK_DOWN, RELEASE, DONE} state_e;
  localparam logic DRV_RELEASE = 1'b1;
  localparam logic DRV_PULL    = 1'b0;
  function automatic int quarter_period(input int clk_freq, input int i2c_freq);
    return clk_freq / (4 * i2c_freq);
  endfunction
endpackage

// File: rtl/i2c_phase_timer.sv
// i2c_phase_timer: loads Q on i_load and counts down to zero; o_expired is high
// at zero, so a wait entered with a load lasts Q+1 cycles.
module i2c_phase_timer #(
  parameter int Q = 62
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_load,
  output logic o_expired
);
  localparam int W = (Q > 0) ? $clog2(Q + 1) : 1;
  logic [W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = i_load ? W'(Q) : ((cnt_q != '0) ? cnt_q - W'(1) : cnt_q);
  always_ff @(posedge i_clk) begin
    if (i_rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
  assign o_expired = (cnt_q == '0);
endmodule

// File: rtl/i2c_byte_gen.sv
// i2c_byte_gen: shifts one byte MSB-first plus the ACK bit over open-drain SDA/SCL.
// Unstretched, o_done is high 9*(3Q+8)+2 clock edges after the accepting edge (that edge counted as 1).
module i2c_byte_gen
  import i2c_pkg::*;
#(
  parameter int CLK_FREQ = 25_000_000,
  parameter int I2C_FREQ = 100_000
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_req,
  input  logic       i_rw,
  input  logic [7:0] i_data,
  input  logic       i_ack,
  output logic       o_ready,
  output logic       o_done,
  output logic [7:0] o_data,
  output logic       o_ack,
  input  logic       i_sda,
  input  logic       i_scl,
  output logic       o_sda_drive,
  output logic       o_scl_drive
);
  localparam int Q = quarter_period(CLK_FREQ, I2C_FREQ);
  state_e state_q, state_d, ret_q, ret_d;
  logic [3:0] bit_q, bit_d;
  logic [7:0] tx_q, tx_d, data_q, data_d;
  logic rw_q, rw_d, mack_q, mack_d, ack_q, ack_d, sda_q, sda_d, scl_q, scl_d;
  logic load, expired;
  i2c_phase_timer #(.Q(Q)) u_timer (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_load   (load),
    .o_expired(expired)
  );
  assign o_ready     = (state_q == IDLE) && !i_scl;
  assign o_done      = (state_q == DONE);
  assign o_data      = data_q;
  assign o_ack       = ack_q;
  assign o_sda_drive = sda_q;
  assign o_scl_drive = scl_q;
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      ret_q   <= IDLE;
      bit_q   <= '0;
      tx_q    <= '0;
      data_q  <= '0;
      rw_q    <= 1'b0;
      mack_q  <= 1'b0;
      ack_q   <= 1'b0;
      sda_q   <= DRV_RELEASE;
      scl_q   <= DRV_RELEASE;
    end else begin
      state_q <= state_d;
      ret_q   <= ret_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
      data_q  <= data_d;
      rw_q    <= rw_d;
      mack_q  <= mack_d;
      ack_q   <= ack_d;
      sda_q   <= sda_d;
      scl_q   <= scl_d;
    end
  end
  // Bit 8 is the ACK slot; the low phase is CLK_DOWN + SDA_SET + one wait.
  always_comb begin
    state_d = state_q;
    ret_d   = ret_q;
    bit_d   = bit_q;
    tx_d    = tx_q;
    data_d  = data_q;
    rw_d    = rw_q;
    mack_d  = mack_q;
    ack_d   = ack_q;
    sda_d   = sda_q;
    scl_d   = scl_q;
    load    = 1'b0;
    case (state_q)
      IDLE: if (i_req && o_ready) begin
        rw_d    = i_rw;
        tx_d    = i_data;
        mack_d  = i_ack;
        data_d  = '0;
        ack_d   = 1'b0;
        bit_d   = '0;
        state_d = SDA_SET;
      end
      WAIT: state_d = expired ? ret_q : WAIT;
      SDA_SET: begin
        scl_d   = DRV_PULL;
        sda_d   = bit_q[3] ? (rw_q ? ~mack_q : DRV_RELEASE)
                           : (rw_q ? DRV_RELEASE : tx_q[3'd7 - bit_q[2:0]]);
        load    = 1'b1;
        ret_d   = CLK_UP;
        state_d = WAIT;
      end
      CLK_UP: begin
        scl_d = DRV_RELEASE;
        if (i_scl) begin
          load    = 1'b1;
          ret_d   = SAMPLE;
          state_d = WAIT;
        end
      end
      SAMPLE: begin
        if (!bit_q[3] && rw_q) data_d = {data_q[6:0], i_sda};
        if (bit_q[3] && !rw_q) ack_d = ~i_sda;
        load    = 1'b1;
        ret_d   = CLK_DOWN;
        state_d = WAIT;
      end
      CLK_DOWN: begin
        scl_d   = DRV_PULL;
        bit_d   = bit_q[3] ? bit_q : bit_q + 4'd1;
        state_d = bit_q[3] ? RELEASE : SDA_SET;
      end
      RELEASE: begin
        sda_d   = DRV_RELEASE;
        scl_d   = DRV_PULL;
        state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_i2c_byte_gen.sv
// tb_i2c_byte_gen: random and directed byte transfers against an open-drain bus
// with a behavioural slave; expectations come from the I2C byte/ACK rules.
module tb_i2c_byte_gen;
  localparam int CLK_FREQ = 400;
  localparam int I2C_FREQ = 100;
  localparam int Q = CLK_FREQ / (4 * I2C_FREQ);
  localparam int BYTE_CYC = 9 * (3 * Q + 8) + 2;
  logic clk = 1'b0, rst = 1'b1, req = 1'b0, rw = 1'b0, mack = 1'b0;
  logic [7:0] din = 8'h00;
  logic ready, done, ack, sda_drv, scl_drv;
  logic [7:0] dout;
  logic slave_sda = 1'b1, slave_scl = 1'b1, gen_scl = 1'b1;
  logic sda_line, scl_line;
  int total = 0, bad = 0;
  logic sl_rw = 1'b0, sl_ack = 1'b0, sl_stretch = 1'b0;
  logic [7:0] sl_byte = 8'h00;
  int xfer_id = 0;
  int sl_id = 0, rises = 0, falls = 0, stall = 0, sda_viol = 0;
  logic stall_done = 1'b0, sda_moved = 1'b0;
  logic [8:0] rise_bits = '0;
  logic prev_scl = 1'b1, prev_sda_drv = 1'b1, prev_scl_drv = 1'b1;

  assign sda_line = sda_drv & slave_sda;
  assign scl_line = scl_drv & slave_scl & gen_scl;

  always #5 clk = ~clk;

  i2c_byte_gen #(.CLK_FREQ(CLK_FREQ), .I2C_FREQ(I2C_FREQ)) dut (
    .i_clk(clk), .i_rst(rst), .i_req(req), .i_rw(rw), .i_data(din), .i_ack(mack),
    .o_ready(ready), .o_done(done), .o_data(dout), .o_ack(ack),
    .i_sda(sda_line), .i_scl(scl_line), .o_sda_drive(sda_drv), .o_scl_drive(scl_drv)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Slave: records SDA at each SCL rise, shifts its byte or ACKs, optionally stretches bit 3.
  always @(negedge clk) begin
    if (sl_id != xfer_id) begin
      sl_id = xfer_id; rises = 0; falls = 0; stall = 0; sda_viol = 0;
      stall_done = 1'b0; sda_moved = 1'b0; rise_bits = '0; slave_sda = 1'b1; slave_scl = 1'b1;
    end
    if (scl_line && !prev_scl) begin
      if (rises < 9) rise_bits[8 - rises] = sda_line;
      rises++;
    end
    if (!scl_line && prev_scl) falls++;
    if (prev_scl_drv && sda_drv != prev_sda_drv) sda_viol++;
    if (sl_stretch && falls == 3 && !stall_done) begin
      slave_scl = 1'b0;
      if (scl_drv) begin
        if (stall > 0 && sda_drv != prev_sda_drv) sda_moved = 1'b1;
        stall++;
        if (stall > 20) begin
          slave_scl = 1'b1;
          stall_done = 1'b1;
        end
      end
    end
    if (!scl_line) slave_sda = sl_rw ? ((rises < 8) ? sl_byte[7 - rises] : 1'b1) : !(falls == 8 && sl_ack);
    prev_scl = scl_line;
    prev_sda_drv = sda_drv;
    prev_scl_drv = scl_drv;
  end

  task automatic xfer(input logic r, input logic [7:0] d, input logic ma, input logic sa,
                      input logic [7:0] sb, input logic st, input logic poke);
    int cyc, dones;
    logic [8:0] exp_bits;
    logic [7:0] exp_data;
    logic exp_ack;
    sl_rw = r; sl_byte = sb; sl_ack = sa; sl_stretch = st; xfer_id++;
    for (int i = 0; i < 50 && !ready; i++) @(negedge clk);
    check("ready", 32'(ready), 32'd1);
    @(negedge clk);
    req = 1'b1; rw = r; din = d; mack = ma;
    @(posedge clk);
    cyc = 1;
    @(negedge clk);
    req = 1'b0; din = 8'($urandom); mack = 1'($urandom); rw = 1'($urandom);
    while (!done && cyc < 4000) begin
      if (!gen_scl && !scl_drv) gen_scl = 1'b1;
      req = poke && cyc == 40;
      @(posedge clk);
      cyc++;
      @(negedge clk);
    end
    req = 1'b0;
    dones = done ? 1 : 0;
    check("sda_end", 32'(sda_drv), 32'd1);
    check("scl_end", 32'(scl_drv), 32'd0);
    repeat (4) begin
      @(negedge clk);
      if (done) dones++;
    end
    exp_bits = r ? {sb, ~ma} : {d, ~sa};
    exp_data = r ? sb : 8'h00;
    exp_ack  = r ? 1'b0 : sa;
    check("done_cnt", 32'(dones), 32'd1);
    check("rises", 32'(rises), 32'd9);
    check("bits", 32'(rise_bits), 32'(exp_bits));
    check("data", 32'(dout), 32'(exp_data));
    check("ack", 32'(ack), 32'(exp_ack));
    check("sda_while_scl_hi", 32'(sda_viol), 32'd0);
    if (st) begin
      check("stretch_dur", 32'(cyc >= BYTE_CYC + 20), 32'd1);
      check("stall_sda", 32'(sda_moved), 32'd0);
    end else check("dur", 32'(cyc), 32'(BYTE_CYC));
  endtask

  initial begin
    int dones;
    logic changed;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_sda", 32'(sda_drv), 32'd1);
    check("rst_scl", 32'(scl_drv), 32'd1);
    check("rst_data", 32'(dout), 32'd0);
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_ready", 32'(ready), 32'd0);
    req = 1'b1; din = 8'hFF;
    changed = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (!sda_drv || !scl_drv || done) changed = 1'b1;
    end
    req = 1'b0;
    check("idle_bus", 32'(changed), 32'd0);
    check("idle_ready", 32'(ready), 32'd0);
    gen_scl = 1'b0;
    @(negedge clk);
    check("ready_low", 32'(ready), 32'd1);
    xfer(1'b0, 8'hA5, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
    xfer(1'b0, 8'h3C, 1'b1, 1'b0, 8'hFF, 1'b0, 1'b0);
    xfer(1'b1, 8'h00, 1'b1, 1'b0, 8'h5A, 1'b0, 1'b0);
    xfer(1'b1, 8'hFF, 1'b0, 1'b1, 8'h5A, 1'b0, 1'b0);
    xfer(1'b0, 8'hA5, 1'b0, 1'b1, 8'h00, 1'b1, 1'b1);
    for (int i = 0; i < 12; i++)
      xfer(1'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), 8'($urandom), 1'(i % 4 == 3), 1'(i % 2));
    sl_rw = 1'b0; sl_ack = 1'b1; sl_stretch = 1'b0; sl_byte = 8'h00; xfer_id++;
    @(negedge clk);
    req = 1'b1; rw = 1'b0; din = 8'h96;
    @(posedge clk);
    @(negedge clk);
    req = 1'b0;
    for (int i = 0; i < 400 && falls < 4; i++) @(negedge clk);
    check("reach_bit4", 32'(falls), 32'd4);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("mid_rst_sda", 32'(sda_drv), 32'd1);
    check("mid_rst_scl", 32'(scl_drv), 32'd1);
    check("mid_rst_done", 32'(done), 32'd0);
    rst = 1'b0;
    dones = 0;
    repeat (150) begin
      @(negedge clk);
      if (done) dones++;
    end
    check("mid_rst_nodone", 32'(dones), 32'd0);
    check("mid_rst_busy", 32'(ready), 32'd0);
    gen_scl = 1'b0;
    @(negedge clk);
    check("mid_rst_idle", 32'(ready), 32'd1);
    xfer(1'b0, 8'h81, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
